// File: rtl/onehot_code_capture_pkg.sv
// Shared widths and defaults for the one-hot capture stage and its decoder.
package onehot_code_capture_pkg;

    localparam int unsigned DEF_CODE_W     = 3;
    localparam int unsigned DEF_D_W        = 1 << DEF_CODE_W;
    localparam int unsigned DEF_FIFO_DEPTH = 4;
    localparam int unsigned DEF_CNT_W      = 8;

    typedef logic [DEF_CODE_W-1:0] code_t;
    typedef logic [DEF_D_W-1:0]    onehot_t;

    // True when exactly one bit of the default-width bus is set.
    function automatic logic is_onehot(input onehot_t d);
        return $countones(d) == 1;
    endfunction

endpackage

// File: rtl/onehot_code_fifo.sv
// Synchronous first-word-fall-through FIFO for captured code indices.
module onehot_code_fifo
    import onehot_code_capture_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_CODE_W,
    parameter int unsigned DEPTH  = DEF_FIFO_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic                    pop,
    input  logic [DATA_W-1:0]       wdata,
    output logic [DATA_W-1:0]       rdata,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_FW = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              pop_ok;
    logic              push_ok;

    // A pop needs data; a push into a full FIFO only lands if a pop frees the slot.
    assign empty   = (count == '0);
    assign full    = (count == CNT_FW'(DEPTH));
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign rdata   = empty ? '0 : mem[rd_ptr];

    // Storage array; contents behind the pointers are don't-care, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_FW'(1);
                2'b01:   count <= count - CNT_FW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/onehot_code_capture.sv
// Samples the decoder's one-hot bus, validates it, and buffers the encoded index.
module onehot_code_capture
    import onehot_code_capture_pkg::*;
#(
    parameter int unsigned CODE_W     = DEF_CODE_W,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int unsigned CNT_W      = DEF_CNT_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sample_en,
    input  logic [(1 << CODE_W)-1:0]     d_in,
    output logic [CODE_W-1:0]            code_out,
    output logic                         code_valid,
    input  logic                         code_ready,
    output logic                         err_onehot,
    output logic                         overflow,
    input  logic                         err_clr,
    output logic [CNT_W-1:0]             hit_cnt,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

    localparam int unsigned D_W = 1 << CODE_W;
    localparam logic [CNT_W-1:0] HIT_MAX = '1;

    logic [D_W-1:0]    d_q;
    logic              s1_v;
    logic              d_onehot;
    logic [CODE_W-1:0] d_code;
    logic              push_req;
    logic              pop_req;
    logic              push_ok;
    logic              drop;
    logic              bad_sample;
    logic              fifo_full;
    logic              fifo_empty;

    // Capture register: holds the sampled bus for one cycle of checking.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_q  <= '0;
            s1_v <= 1'b0;
        end else begin
            s1_v <= sample_en;
            if (sample_en) begin
                d_q <= d_in;
            end
        end
    end

    // One-hot check and priority-free encode (only meaningful when one-hot).
    always_comb begin
        d_onehot = ($countones(d_q) == 1);
        d_code   = '0;
        for (int unsigned i = 0; i < D_W; i++) begin
            if (d_q[i]) begin
                d_code = CODE_W'(i);
            end
        end
    end

    // Push/pop qualification; full-with-pop lets the push through.
    assign push_req   = s1_v & d_onehot;
    assign bad_sample = s1_v & ~d_onehot;
    assign pop_req    = code_valid & code_ready;
    assign push_ok    = push_req & (~fifo_full | pop_req);
    assign drop       = push_req & fifo_full & ~pop_req;
    assign code_valid = ~fifo_empty;

    onehot_code_fifo #(
        .DATA_W (CODE_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req),
        .pop   (pop_req),
        .wdata (d_code),
        .rdata (code_out),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Sticky error flags; a fresh error in the clear cycle keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_onehot <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (bad_sample) begin
                err_onehot <= 1'b1;
            end else if (err_clr) begin
                err_onehot <= 1'b0;
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    // Saturating count of codes that made it into the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt <= '0;
        end else if (push_ok && (hit_cnt != HIT_MAX)) begin
            hit_cnt <= hit_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_onehot_code_capture.sv
// Bench for onehot_code_capture: queue-based reference model plus directed tests.
module tb_onehot_code_capture;

    localparam int DEPTH   = 4;
    localparam int HIT_MAX = 255;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sample_en = 1'b0;
    logic [7:0] d_in = 8'h00;
    logic       code_ready = 1'b0;
    logic       err_clr = 1'b0;
    logic [2:0] code_out;
    logic       code_valid;
    logic       err_onehot;
    logic       overflow;
    logic [7:0] hit_cnt;
    logic [2:0] fifo_count;

    int nvec = 0;
    int nmis = 0;
    bit chk_en = 1'b0;

    // Reference model state
    int   mq[$];
    bit   m_pend_v = 1'b0;
    logic [7:0] m_pend_d = 8'h00;
    bit   m_err = 1'b0;
    bit   m_ovf = 1'b0;
    int   m_hit = 0;

    onehot_code_capture dut (
        .clk        (clk),
        .rst        (rst),
        .sample_en  (sample_en),
        .d_in       (d_in),
        .code_out   (code_out),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .err_onehot (err_onehot),
        .overflow   (overflow),
        .err_clr    (err_clr),
        .hit_cnt    (hit_cnt),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    function automatic int ones(input logic [7:0] v);
        int n = 0;
        for (int i = 0; i < 8; i++) if (v[i]) n++;
        return n;
    endfunction

    function automatic int bit_index(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Model: what the outputs must become after this edge, from the behavioural rules.
    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_pend_v = 1'b0;
            m_err    = 1'b0;
            m_ovf    = 1'b0;
            m_hit    = 0;
        end else begin
            bit do_pop;
            bit new_err;
            bit new_ovf;
            do_pop  = (mq.size() > 0) && code_ready;
            new_err = 1'b0;
            new_ovf = 1'b0;
            if (do_pop) void'(mq.pop_front());
            if (m_pend_v) begin
                if (ones(m_pend_d) == 1) begin
                    if (mq.size() < DEPTH) begin
                        mq.push_back(bit_index(m_pend_d));
                        if (m_hit < HIT_MAX) m_hit++;
                    end else begin
                        new_ovf = 1'b1;
                    end
                end else begin
                    new_err = 1'b1;
                end
            end
            m_err    = new_err ? 1'b1 : (err_clr ? 1'b0 : m_err);
            m_ovf    = new_ovf ? 1'b1 : (err_clr ? 1'b0 : m_ovf);
            m_pend_v = sample_en;
            m_pend_d = d_in;
        end
    end

    // Cycle-by-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            int e_code;
            e_code = (mq.size() > 0) ? mq[0] : 0;
            nvec++;
            if (code_valid !== (mq.size() > 0) || int'(code_out) != e_code ||
                int'(fifo_count) != mq.size() || int'(hit_cnt) != m_hit ||
                err_onehot !== m_err || overflow !== m_ovf || $isunknown(code_out)) begin
                nmis++;
                $display("FAIL model t=%0t: got v=%0b code=%0d cnt=%0d hit=%0d err=%0b ovf=%0b, want v=%0b code=%0d cnt=%0d hit=%0d err=%0b ovf=%0b",
                         $time, code_valid, code_out, fifo_count, hit_cnt, err_onehot, overflow,
                         mq.size() > 0, e_code, mq.size(), m_hit, m_err, m_ovf);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nmis++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic se, input logic [7:0] d,
                        input logic rdy, input logic clr);
        rst        = r;
        sample_en  = se;
        d_in       = d;
        code_ready = rdy;
        err_clr    = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] pat;
        logic [7:0] seq3 [5];
        seq3[0] = 8'h01; seq3[1] = 8'h02; seq3[2] = 8'h04; seq3[3] = 8'h08; seq3[4] = 8'h10;

        // Reset state
        step(1, 0, 8'h00, 0, 0);
        chk_en = 1'b1;
        step(1, 0, 8'h00, 0, 0);
        chk("rst_valid", int'(code_valid), 0);
        chk("rst_count", int'(fifo_count), 0);
        chk("rst_hit", int'(hit_cnt), 0);
        chk("rst_flags", int'({err_onehot, overflow}), 0);

        // 1: single sample, two-edge latency, then popped
        step(0, 1, 8'b0000_0100, 1, 0);
        chk("t1_not_yet", int'(code_valid), 0);
        step(0, 0, 8'h00, 1, 0);
        chk("t1_valid", int'(code_valid), 1);
        chk("t1_code", int'(code_out), 2);
        chk("t1_hit", int'(hit_cnt), 1);
        step(0, 0, 8'h00, 1, 0);
        chk("t1_drained", int'(code_valid), 0);

        // 2: zero-hot and multi-hot samples
        step(0, 1, 8'h00, 1, 0);
        step(0, 1, 8'h11, 1, 0);
        chk("t2_err_zero", int'(err_onehot), 1);
        step(0, 0, 8'h00, 1, 0);
        chk("t2_err", int'(err_onehot), 1);
        chk("t2_hit", int'(hit_cnt), 1);
        chk("t2_nopush", int'(code_valid), 0);
        step(0, 0, 8'h00, 1, 1);
        chk("t2_clr", int'(err_onehot), 0);

        // 3: overfill with ready low, then drain in order
        for (int i = 0; i < 5; i++) step(0, 1, seq3[i], 0, 0);
        step(0, 0, 8'h00, 0, 0);
        chk("t3_count", int'(fifo_count), 4);
        chk("t3_ovf", int'(overflow), 1);
        chk("t3_hit", int'(hit_cnt), 5);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t3_drain%0d", i), int'(code_out), i);
            step(0, 0, 8'h00, 1, (i == 0) ? 1'b1 : 1'b0);
        end
        chk("t3_empty", int'(code_valid), 0);
        chk("t3_ovf_clr", int'(overflow), 0);

        // 4: push and pop in the same edge while full
        for (int i = 0; i < 4; i++) step(0, 1, seq3[i], 0, 0);
        step(0, 1, 8'h80, 0, 0);
        chk("t4_full", int'(fifo_count), 4);
        step(0, 0, 8'h00, 1, 0);
        chk("t4_count", int'(fifo_count), 4);
        chk("t4_no_ovf", int'(overflow), 0);
        chk("t4_hit", int'(hit_cnt), 10);
        begin
            int exp4 [4];
            exp4[0] = 1; exp4[1] = 2; exp4[2] = 3; exp4[3] = 7;
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("t4_order%0d", i), int'(code_out), exp4[i]);
                step(0, 0, 8'h00, 1, 0);
            end
        end
        chk("t4_empty", int'(code_valid), 0);

        // 5: reset with buffered codes and a sample in flight
        for (int i = 0; i < 4; i++) step(0, 1, seq3[i], 0, 0);
        chk("t5_count3", int'(fifo_count), 3);
        step(1, 1, 8'h10, 0, 0);
        chk("t5_rst_all", int'({code_valid, code_out, fifo_count, hit_cnt, err_onehot, overflow}), 0);
        step(0, 0, 8'h00, 0, 0);
        chk("t5_no_late", int'(fifo_count), 0);
        chk("t5_hit", int'(hit_cnt), 0);

        // 6: all eight patterns back-to-back at full rate
        for (int j = 0; j <= 8; j++) begin
            pat = 8'h01 << (j % 8);
            step(0, (j < 8) ? 1'b1 : 1'b0, pat, 1, 0);
            if (j >= 1) begin
                chk($sformatf("t6_valid%0d", j - 1), int'(code_valid), 1);
                chk($sformatf("t6_code%0d", j - 1), int'(code_out), j - 1);
            end
        end
        step(0, 0, 8'h00, 1, 0);
        chk("t6_hit", int'(hit_cnt), 8);
        chk("t6_flags", int'({err_onehot, overflow}), 0);
        chk("t6_empty", int'(code_valid), 0);

        // 7: hit counter saturation
        for (int j = 0; j < 252; j++) step(0, 1, 8'h40, 1, 0);
        step(0, 0, 8'h00, 1, 0);
        step(0, 0, 8'h00, 1, 0);
        chk("t7_sat", int'(hit_cnt), 255);
        chk("t7_flags", int'({err_onehot, overflow}), 0);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
